// File: rtl/machine_control.sv
// Trap/interrupt controller for pipeline stage 2.
// Sequences cause/epc/mie strobes, PC source select and flush for traps and MRET.
module machine_control (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ahb_ready_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_OPER  = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;
  localparam logic [1:0] S_RET   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic       ior_q, ior_d;

  logic       irq_ext, irq_sw, irq_tmr;
  logic       irq_pend, exc_pend, trap_ev;
  logic [3:0] trap_cause;

  assign irq_ext  = mie_in & meie_in & meip_in;
  assign irq_sw   = mie_in & msie_in & msip_in;
  assign irq_tmr  = mie_in & mtie_in & mtip_in;
  assign irq_pend = irq_ext | irq_sw | irq_tmr;

  assign exc_pend = illegal_instr_in | misaligned_instr_in
                  | misaligned_load_in | misaligned_store_in
                  | ecall_in | ebreak_in;

  assign trap_ev = irq_pend | exc_pend;

  // Interrupts first, then exceptions in fixed priority order
  always_comb begin
    trap_cause = 4'd0;
    if (irq_ext)                  trap_cause = 4'd11;
    else if (irq_sw)              trap_cause = 4'd3;
    else if (irq_tmr)             trap_cause = 4'd7;
    else if (misaligned_instr_in) trap_cause = 4'd0;
    else if (illegal_instr_in)    trap_cause = 4'd2;
    else if (ebreak_in)           trap_cause = 4'd3;
    else if (ecall_in)            trap_cause = 4'd11;
    else if (misaligned_load_in)  trap_cause = 4'd4;
    else if (misaligned_store_in) trap_cause = 4'd6;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ior_d   = ior_q;
    unique case (state_q)
      S_RESET: state_d = S_OPER;
      S_OPER: begin
        if (ahb_ready_in) begin
          if (trap_ev) begin
            state_d = S_TRAP;
            cause_d = trap_cause;
            ior_d   = irq_pend;
          end else if (mret_in) begin
            state_d = S_RET;
          end
        end
      end
      S_TRAP:  state_d = S_OPER;
      S_RET:   state_d = S_OPER;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_RESET;
      cause_q <= 4'd0;
      ior_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ior_q   <= ior_d;
    end
  end

  assign i_or_e_out     = ior_q;
  assign cause_out      = cause_q;
  assign set_cause_out  = (state_q == S_TRAP);
  assign set_epc_out    = (state_q == S_TRAP);
  assign mie_clear_out  = (state_q == S_TRAP);
  assign trap_taken_out = (state_q == S_TRAP);
  assign mie_set_out    = (state_q == S_RET);
  assign flush_out      = (state_q != S_OPER);

  // Retire count is the only path from inputs straight to an output
  assign instret_inc_out = (state_q == S_OPER) & ahb_ready_in
                         & ~trap_ev & ~mret_in;

  always_comb begin
    pc_src_out = 2'b00;
    unique case (state_q)
      S_RESET: pc_src_out = 2'b00;
      S_OPER:  pc_src_out = 2'b11;
      S_TRAP:  pc_src_out = 2'b10;
      S_RET:   pc_src_out = 2'b01;
      default: pc_src_out = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_machine_control.sv
// Bench for machine_control: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a behavioural model.
module tb_machine_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rdy, ill, mi, ml, ms, ec, eb, mr;
  logic mie, meie, mtie, msie, meip, mtip, msip;
  logic       ior, scause, sepc, mclr, mset, iinc, flush, ttk;
  logic [3:0] cause;
  logic [1:0] pcs;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: 0 reset, 1 running, 2 trap entry, 3 trap return
  int         m_mode  = 0;
  logic [3:0] m_cause = 4'd0;
  logic       m_ior   = 1'b0;

  machine_control dut (
    .clk_in(clk), .rst_in(rst_n), .ahb_ready_in(rdy),
    .illegal_instr_in(ill), .misaligned_instr_in(mi),
    .misaligned_load_in(ml), .misaligned_store_in(ms),
    .ecall_in(ec), .ebreak_in(eb), .mret_in(mr),
    .mie_in(mie), .meie_in(meie), .mtie_in(mtie), .msie_in(msie),
    .meip_in(meip), .mtip_in(mtip), .msip_in(msip),
    .i_or_e_out(ior), .cause_out(cause), .set_cause_out(scause),
    .set_epc_out(sepc), .mie_clear_out(mclr), .mie_set_out(mset),
    .instret_inc_out(iinc), .pc_src_out(pcs), .flush_out(flush),
    .trap_taken_out(ttk)
  );

  function automatic int irq_code();
    if (!mie) return -1;
    if (meie && meip) return 11;
    if (msie && msip) return 3;
    if (mtie && mtip) return 7;
    return -1;
  endfunction

  function automatic int exc_code();
    int tbl[6];
    bit flg[6];
    tbl = '{0, 2, 3, 11, 4, 6};
    flg = '{mi, ill, eb, ec, ml, ms};
    for (int i = 0; i < 6; i++)
      if (flg[i]) return tbl[i];
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cause = 4'd0; m_ior = 1'b0;
    end else if (m_mode != 1) begin
      m_mode = 1;
    end else if (rdy) begin
      if (irq_code() >= 0) begin
        m_mode = 2; m_cause = 4'(irq_code()); m_ior = 1'b1;
      end else if (exc_code() >= 0) begin
        m_mode = 2; m_cause = 4'(exc_code()); m_ior = 1'b0;
      end else if (mr) begin
        m_mode = 3;
      end
    end
  end

  task automatic chk(string nm, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_pc(int md);
    case (md)
      1: return 2'b11;
      2: return 2'b10;
      3: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic ei;
      ei = (m_mode == 1) && rdy && irq_code() < 0
           && exc_code() < 0 && !mr;
      chk("m_pc", 4'(pcs), 4'(exp_pc(m_mode)));
      chk("m_flush", 4'(flush), 4'(m_mode != 1));
      chk("m_setc", 4'(scause), 4'(m_mode == 2));
      chk("m_epc", 4'(sepc), 4'(m_mode == 2));
      chk("m_mclr", 4'(mclr), 4'(m_mode == 2));
      chk("m_ttk", 4'(ttk), 4'(m_mode == 2));
      chk("m_mset", 4'(mset), 4'(m_mode == 3));
      chk("m_inst", 4'(iinc), 4'(ei));
      chk("m_cause", cause, m_cause);
      chk("m_ior", 4'(ior), 4'(m_ior));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #2;
  endtask

  task automatic clr();
    {ill, mi, ml, ms, ec, eb, mr} = '0;
    {mie, meie, mtie, msie, meip, mtip, msip} = '0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clr();
    chk_en = 1'b1;
    #12;
    chk("rst_pc", 4'(pcs), 4'd0);
    chk("rst_flush", 4'(flush), 4'd1);
    chk("rst_cause", cause, 4'd0);
    tick(); rst_n = 1'b1;
    look();
    chk("rel_pc", 4'(pcs), 4'd0);
    tick(); look();
    chk("op_pc", 4'(pcs), 4'd3);
    chk("op_inst", 4'(iinc), 4'd1);
    // illegal instruction
    tick(); ill = 1'b1; look();
    chk("ill_inst", 4'(iinc), 4'd0);
    tick(); ill = 1'b0; look();
    chk("ill_setc", 4'(scause), 4'd1);
    chk("ill_pc", 4'(pcs), 4'd2);
    chk("ill_cause", cause, 4'd2);
    chk("ill_ior", 4'(ior), 4'd0);
    tick(); look();
    chk("ill_back", 4'(pcs), 4'd3);
    chk("ill_hold", cause, 4'd2);
    // external interrupt beats timer and ecall
    tick(); mie = 1; meie = 1; meip = 1; mtie = 1; mtip = 1; ec = 1;
    tick(); clr(); look();
    chk("ext_cause", cause, 4'd11);
    chk("ext_ior", 4'(ior), 4'd1);
    // timer masked by mie, then enabled
    tick(); mtie = 1; mtip = 1; look();
    chk("msk_inst", 4'(iinc), 4'd1);
    tick(); chk("msk_pc", 4'(pcs), 4'd3);
    mie = 1;
    tick(); clr(); look();
    chk("tmr_cause", cause, 4'd7);
    chk("tmr_ttk", 4'(ttk), 4'd1);
    // mret alone, then mret with ebreak
    tick(); mr = 1; look();
    chk("mret_inst", 4'(iinc), 4'd0);
    tick(); mr = 0; look();
    chk("mret_set", 4'(mset), 4'd1);
    chk("mret_pc", 4'(pcs), 4'd1);
    chk("mret_cause", cause, 4'd7);
    tick(); mr = 1; eb = 1;
    tick(); clr(); look();
    chk("mreb_cause", cause, 4'd3);
    chk("mreb_ior", 4'(ior), 4'd0);
    // stall with ecall pending
    tick(); rdy = 0; ec = 1;
    tick(); look();
    chk("stl_pc", 4'(pcs), 4'd3);
    chk("stl_setc", 4'(scause), 4'd0);
    chk("stl_inst", 4'(iinc), 4'd0);
    tick(); rdy = 1;
    tick(); clr(); look();
    chk("stl_cause", cause, 4'd11);
    chk("stl_ttk", 4'(ttk), 4'd1);
    #1 rst_n = 1'b0; #1;
    chk("arst_pc", 4'(pcs), 4'd0);
    chk("arst_setc", 4'(scause), 4'd0);
    chk("arst_cause", cause, 4'd0);
    chk("arst_flush", 4'(flush), 4'd1);
    tick(); rst_n = 1'b1;
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      rdy = ($urandom_range(0, 4) != 0);
      ill = ($urandom_range(0, 15) == 0);
      mi  = ($urandom_range(0, 15) == 0);
      ml  = ($urandom_range(0, 15) == 0);
      ms  = ($urandom_range(0, 15) == 0);
      ec  = ($urandom_range(0, 15) == 0);
      eb  = ($urandom_range(0, 15) == 0);
      mr  = ($urandom_range(0, 7) == 0);
      mie  = $urandom_range(0, 1);
      meie = ($urandom_range(0, 3) == 0);
      mtie = ($urandom_range(0, 3) == 0);
      msie = ($urandom_range(0, 3) == 0);
      meip = ($urandom_range(0, 2) == 0);
      mtip = ($urandom_range(0, 2) == 0);
      msip = ($urandom_range(0, 2) == 0);
    end
    tick(); rst_n = 1'b1; clr();
    look();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/machine_control.md
Name: machine_control

Overview:
- Trap/interrupt controller FSM in pipeline stage 2, directly upstream of the CSR file.
- Watches exception flags from the decoder and pending/enabled interrupt bits returned by the CSR file.
- Drives the CSR file's cause/epc/mie strobes and the program-counter source select.
- Issues a pipeline flush whenever a trap is taken or an MRET executes.

Parameters:
- none

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- ahb_ready_in  input  1  1 = pipeline advancing; 0 = stall
- illegal_instr_in  input  1  decoder flag
- misaligned_instr_in  input  1  target address not 4-byte aligned
- misaligned_load_in  input  1  load address misaligned
- misaligned_store_in  input  1  store address misaligned
- ecall_in  input  1  ECALL decoded
- ebreak_in  input  1  EBREAK decoded
- mret_in  input  1  MRET decoded
- mie_in  input  1  mstatus.MIE from CSR file
- meie_in, mtie_in, msie_in  input  1 each  interrupt enables from CSR file
- meip_in, mtip_in, msip_in  input  1 each  interrupt pending from CSR file
- i_or_e_out  output  1  1 = interrupt, 0 = exception
- cause_out  output  4  trap cause code
- set_cause_out  output  1  CSR file latches i_or_e/cause into mcause
- set_epc_out  output  1  CSR file latches PC into mepc
- mie_clear_out  output  1  MPIE<=MIE, MIE<=0
- mie_set_out  output  1  MIE<=MPIE, MPIE<=1
- instret_inc_out  output  1  minstret increment
- pc_src_out  output  2  00 boot, 01 epc, 10 trap address, 11 next PC
- flush_out  output  1  kill instruction in stage 2
- trap_taken_out  output  1  high in TRAP_TAKEN state

Behaviour:
- Reset is asynchronous and active-low on rst_in.
  - During reset: state=RESET, cause_out=0, i_or_e_out=0.
  - All strobes are 0, pc_src_out=00, flush_out=1.
- States and outputs (all outputs decoded from registered state plus registered cause/i_or_e; no combinational input-to-output path):
  - RESET: pc_src=00, flush=1. Next cycle after reset release -> OPERATING, regardless of ahb_ready_in.
  - OPERATING: pc_src=11, flush=0. instret_inc_out = ahb_ready_in AND no trap event AND NOT mret_in; this term is the only combinational term.
  - TRAP_TAKEN: set_cause=1, set_epc=1, mie_clear=1, pc_src=10, flush=1, trap_taken=1. Lasts exactly one cycle, then OPERATING.
  - TRAP_RETURN: mie_set=1, pc_src=01, flush=1. Lasts exactly one cycle, then OPERATING.
- Trap event (sampled in OPERATING only, and only when ahb_ready_in=1):
  - Interrupt pending = mie_in AND ((meie_in AND meip_in) OR (msie_in AND msip_in) OR (mtie_in AND mtip_in)).
  - Exception pending = OR of illegal, misaligned_instr, misaligned_load, misaligned_store, ecall, ebreak.
- Transitions out of OPERATING:
  - Trap event -> TRAP_TAKEN, latching cause_out and i_or_e_out on the same edge.
  - Else mret_in -> TRAP_RETURN.
  - Else stay in OPERATING.
  - Trap event beats mret_in when both are present.
- Priority, highest first:
  - Interrupts over exceptions.
  - Interrupts: external cause 11, software cause 3, timer cause 7. i_or_e=1.
  - Exceptions: misaligned_instr 0, illegal 2, ebreak 3, ecall 11, misaligned_load 4, misaligned_store 6. i_or_e=0.
- cause_out/i_or_e_out hold their value until the next TRAP_TAKEN entry; they are not cleared on return.
- Stall: with ahb_ready_in=0 in OPERATING, the state holds, no trap is sampled and instret_inc=0. TRAP_TAKEN and TRAP_RETURN complete regardless of stall.
- Latency: trap condition at edge N -> strobes and pc_src=10 during cycle N+1 -> back to OPERATING at N+2.
- Reset asserted in any state returns to RESET immediately; a partially issued trap is abandoned.

Test Plan:
- Release reset with ahb_ready=1 -> first cycle pc_src=00, flush=1; second cycle pc_src=11, instret_inc=1, all strobes 0.
- illegal_instr_in=1 for one cycle in OPERATING -> next cycle: set_cause=set_epc=mie_clear=1, cause=2, i_or_e=0, pc_src=10, flush=1; following cycle: OPERATING, cause still 2.
- mie=1, meie=meip=1, mtie=mtip=1, ecall=1 simultaneously -> cause=11, i_or_e=1 (external interrupt wins).
- mie=0 with mtie=mtip=1 -> no trap, instret_inc=1; then set mie=1 -> TRAP_TAKEN, cause=7, i_or_e=1.
- mret_in=1 -> one cycle of mie_set=1, pc_src=01, flush=1, instret_inc=0; mret_in+ebreak_in together -> TRAP_TAKEN, cause=3.
- ahb_ready=0 with ecall=1 -> state holds, no strobes, instret_inc=0; ahb_ready=1 -> trap taken, cause=11. Assert rst_in low during TRAP_TAKEN -> outputs return to reset values asynchronously.
